// File: rtl/msdap_pkg.sv
// Shared definitions for the MSDAP u_j datapath.
//   DATA_W / ACC_W / FRAC_W / NBANDS : datapath widths and band count
//   state_t                          : uj_sequencer controller states
//   COEF_SIGN / COEF_K_*             : coefficient word field positions
//   align_sample()                   : sign-extends a sample and places it
//                                      FRAC_W bits up inside an ACC_W word
package msdap_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int FRAC_W = 16;
  localparam int NBANDS = 16;

  // Coefficient word: [8] = subtract, [7:0] = delay k
  localparam int COEF_SIGN = 8;
  localparam int COEF_K_HI = 7;
  localparam int COEF_K_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    RJ_RD,
    RJ_CAP,
    CF_RD,
    X_RD,
    ACC,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [ACC_W-1:0] align_sample(input logic [DATA_W-1:0] x);
    return {{(ACC_W-FRAC_W-DATA_W){x[DATA_W-1]}}, x, {FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/uj_accumulator.sv
// Signed u_j accumulator for one band.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : zero u at the start of a band
//   en           : add/subtract the aligned sample this cycle
//   sub          : 1 = subtract the operand, 0 = add
//   x            : raw sample from the data buffer
//   u            : running u_j (wraps mod 2^ACC_W, no saturation)
module uj_accumulator
  import msdap_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic              sub,
  input  logic [DATA_W-1:0] x,
  output logic [ACC_W-1:0]  u
);

  logic [ACC_W-1:0] operand;

  assign operand = align_sample(x);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      u <= '0;
    end else if (clear) begin
      u <= '0;
    end else if (en) begin
      u <= sub ? (u - operand) : (u + operand);
    end
  end

endmodule

// File: rtl/uj_sequencer.sv
// Per-sample u_j controller: walks the NBANDS bands, fetches each band's
// coefficient count, coefficients and delayed samples, accumulates u_j and
// folds it into y by Horner shift-add.
//   Sclk, Reset_n      : clock, synchronous active-low reset
//   start, n           : start pulse and newest-sample buffer address
//   busy               : high from accepted start through the y_valid cycle
//   rj_addr / rj_data  : band coefficient-count memory port
//   coef_addr/coef_data: coefficient memory port ([8] sign, [7:0] delay)
//   x_addr / x_data    : sample buffer port
//   y, y_valid         : result and one-cycle update strobe
// Optional build macro UJ_TAP_EN adds uj_out / uj_idx / uj_valid, which
// expose u_j and its band index during every SHIFT cycle.
// Memory data is used in the cycle after the address register is loaded.
module uj_sequencer
  import msdap_pkg::*;
(
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [7:0]        n,
  output logic              busy,
  output logic [3:0]        rj_addr,
  input  logic [7:0]        rj_data,
  output logic [8:0]        coef_addr,
  input  logic [8:0]        coef_data,
  output logic [7:0]        x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [ACC_W-1:0]  y,
  output logic              y_valid
`ifdef UJ_TAP_EN
  ,
  output logic [ACC_W-1:0]  uj_out,
  output logic [3:0]        uj_idx,
  output logic              uj_valid
`endif
);

  state_t           state;
  logic [7:0]       n_reg;
  logic [3:0]       j;
  logic [8:0]       ptr;
  logic [7:0]       cnt;
  logic             sign;
  logic [ACC_W-1:0] y_acc;
  logic [ACC_W-1:0] u_j;
  logic [ACC_W-1:0] y_sum;

  assign y_sum = y_acc + u_j;

  uj_accumulator u_acc (
    .clk     (Sclk),
    .reset_n (Reset_n),
    .clear   (state == RJ_CAP),
    .en      (state == ACC),
    .sub     (sign),
    .x       (x_data),
    .u       (u_j)
  );

`ifdef UJ_TAP_EN
  // Tap is a view of live state during SHIFT; reset forces all three to 0.
  assign uj_valid = (state == SHIFT);
  assign uj_out   = (state == SHIFT) ? u_j : '0;
  assign uj_idx   = (state == SHIFT) ? j : 4'd0;
`endif

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      y_valid   <= 1'b0;
      y         <= '0;
      y_acc     <= '0;
      rj_addr   <= '0;
      coef_addr <= '0;
      x_addr    <= '0;
      ptr       <= '0;
      j         <= '0;
      n_reg     <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          // busy is still high in the y_valid cycle, so a start there is
          // ignored as well.
          if (start && !busy) begin
            n_reg <= n;
            y_acc <= '0;
            j     <= '0;
            ptr   <= '0;
            busy  <= 1'b1;
            state <= RJ_RD;
          end
        end
        RJ_RD: begin
          rj_addr <= j;
          state   <= RJ_CAP;
        end
        RJ_CAP: begin
          cnt   <= rj_data;
          state <= (rj_data == 8'd0) ? SHIFT : CF_RD;
        end
        CF_RD: begin
          coef_addr <= ptr;
          ptr       <= ptr + 9'd1;
          state     <= X_RD;
        end
        X_RD: begin
          // 8-bit subtraction wraps around the circular sample buffer.
          x_addr <= n_reg - coef_data[COEF_K_HI:COEF_K_LO];
          sign   <= coef_data[COEF_SIGN];
          state  <= ACC;
        end
        ACC: begin
          cnt   <= cnt - 8'd1;
          state <= (cnt == 8'd1) ? SHIFT : CF_RD;
        end
        SHIFT: begin
          y_acc <= ACC_W'($signed(y_sum) >>> 1);
          if (j == 4'(NBANDS - 1)) begin
            state <= DONE;
          end else begin
            j     <= j + 4'd1;
            state <= RJ_RD;
          end
        end
        DONE: begin
          y       <= y_acc;
          y_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uj_sequencer.sv
module tb_uj_sequencer;
  import msdap_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        n_in;
  logic              busy;
  logic [3:0]        rj_addr;
  logic [7:0]        rj_data;
  logic [8:0]        coef_addr;
  logic [8:0]        coef_data;
  logic [7:0]        x_addr;
  logic [DATA_W-1:0] x_data;
  logic [ACC_W-1:0]  y;
  logic              y_valid;
`ifdef UJ_TAP_EN
  logic [ACC_W-1:0]  uj_out;
  logic [3:0]        uj_idx;
  logic              uj_valid;
`endif

  logic [7:0]        rj_mem   [16];
  logic [8:0]        coef_mem [512];
  logic [DATA_W-1:0] x_mem    [256];

  // Memories answer in the cycle after the DUT loads its address register.
  assign rj_data   = rj_mem[rj_addr];
  assign coef_data = coef_mem[coef_addr];
  assign x_data    = x_mem[x_addr];

  typedef struct {
    logic [ACC_W-1:0] y;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  bit   busy_log[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uj_sequencer dut (
    .Sclk      (clk),
    .Reset_n   (rst_n),
    .start     (start),
    .n         (n_in),
    .busy      (busy),
    .rj_addr   (rj_addr),
    .rj_data   (rj_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .y         (y),
    .y_valid   (y_valid)
`ifdef UJ_TAP_EN
    ,
    .uj_out    (uj_out),
    .uj_idx    (uj_idx),
    .uj_valid  (uj_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden Horner model straight from the algorithm description.
  function automatic logic [ACC_W-1:0] golden_y(input logic [7:0] nn);
    logic signed [ACC_W-1:0] yacc;
    logic signed [ACC_W-1:0] u;
    logic signed [ACC_W-1:0] op;
    logic [8:0]              p;
    logic [8:0]              cw;
    logic [7:0]              a;
    yacc = '0;
    p    = '0;
    for (int b = 0; b < NBANDS; b++) begin
      u = '0;
      for (int c = 0; c < int'(rj_mem[b]); c++) begin
        cw = coef_mem[p];
        p  = p + 9'd1;
        a  = nn - cw[7:0];
        op = {{8{x_mem[a][15]}}, x_mem[a], 16'h0000};
        u  = cw[8] ? (u - op) : (u + op);
      end
      yacc = (yacc + u) >>> 1;
    end
    return yacc;
  endfunction

  function automatic int golden_lat();
    int s;
    s = 0;
    for (int b = 0; b < NBANDS; b++) s += int'(rj_mem[b]);
    return 3 * NBANDS + 3 * s + 1;
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 16; i++)  rj_mem[i]   = 8'd0;
    for (int i = 0; i < 512; i++) coef_mem[i] = 9'd0;
    for (int i = 0; i < 256; i++) x_mem[i]    = '0;
  endtask

  task automatic setup_random();
    clear_mems();
    for (int i = 0; i < 16; i++)  rj_mem[i]   = 8'd2;
    for (int i = 0; i < 32; i++)  coef_mem[i] = 9'($urandom_range(0, 511));
    for (int i = 0; i < 256; i++) x_mem[i]    = 16'($urandom_range(0, 65535));
  endtask

  // Push the expectation, pulse start, wait (bounded) for y_valid.
  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_sample(input logic [7:0] nn, output int lat,
                            output logic [ACC_W-1:0] got, output bit yv_after,
                            output bit timed_out);
    exp_t e;
    e.y   = golden_y(nn);
    e.lat = golden_lat();
    exp_q.push_back(e);
    busy_log.delete();
    timed_out = 1'b0;
    n_in  = nn;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      busy_log.push_back(busy);
      if (y_valid) break;
      if (lat >= 1000) begin
        timed_out = 1'b1;
        break;
      end
    end
    got = y;
    @(posedge clk);
    #1;
    busy_log.push_back(busy);
    yv_after = y_valid;
    $display("run n=%0d latency=%0d y=%h expected=%h", nn, lat, got, e.y);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    n_in  = '0;
    clear_mems();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (y_valid !== 1'b0)   begin n_err++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
    n_cmp++; if (y !== '0)           begin n_err++; $display("FAIL reset_y got=%h want=0", y); end
    n_cmp++; if (rj_addr !== 4'd0)   begin n_err++; $display("FAIL reset_rj_addr got=%h want=0", rj_addr); end
    n_cmp++; if (coef_addr !== 9'd0) begin n_err++; $display("FAIL reset_coef_addr got=%h want=0", coef_addr); end
    n_cmp++; if (x_addr !== 8'd0)    begin n_err++; $display("FAIL reset_x_addr got=%h want=0", x_addr); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_bands();
    int lat; logic [ACC_W-1:0] got; bit yv2; bit to; exp_t e; bit ok;
    clear_mems();
    run_sample(8'd5, lat, got, yv2, to);
    e = exp_q.pop_front();
    n_cmp++; if (to)           begin n_err++; $display("FAIL zero_timeout got=timeout want=y_valid"); end
    n_cmp++; if (got !== e.y)  begin n_err++; $display("FAIL zero_y got=%h want=%h", got, e.y); end
    n_cmp++; if (lat != 49)    begin n_err++; $display("FAIL zero_latency got=%0d want=49", lat); end
    n_cmp++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL zero_y_valid_width got=%b want=0", yv2); end
    ok = (busy_log.size() >= 50);
    if (ok) begin
      for (int k = 1; k <= 49; k++) if (busy_log[k-1] !== 1'b1) ok = 1'b0;
      if (busy_log[49] !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL zero_busy_window got=mismatch want=high_1_to_49_low_50"); end
  endtask

  task automatic test_single_tap();
    int lat; logic [ACC_W-1:0] got; bit yv2; bit to; exp_t e;
    clear_mems();
    rj_mem[0]   = 8'd1;
    coef_mem[0] = 9'h000;
    x_mem[5]    = 16'h0001;
    run_sample(8'd5, lat, got, yv2, to);
    e = exp_q.pop_front();
    n_cmp++; if (got !== e.y)            begin n_err++; $display("FAIL single_y got=%h want=%h", got, e.y); end
    n_cmp++; if (got !== 40'h0000000001) begin n_err++; $display("FAIL single_y_const got=%h want=0000000001", got); end
    n_cmp++; if (lat != e.lat)           begin n_err++; $display("FAIL single_latency got=%0d want=%0d", lat, e.lat); end
  endtask

  task automatic test_wrap();
    int lat; logic [ACC_W-1:0] got; bit yv2; bit to; exp_t e;
    clear_mems();
    rj_mem[15]  = 8'd1;
    coef_mem[0] = 9'h102;
    x_mem[255]  = 16'h7FFF;
    run_sample(8'd1, lat, got, yv2, to);
    e = exp_q.pop_front();
    n_cmp++; if (got !== e.y)            begin n_err++; $display("FAIL wrap_y got=%h want=%h", got, e.y); end
    n_cmp++; if (got !== 40'hFFC0008000) begin n_err++; $display("FAIL wrap_y_const got=%h want=ffc0008000", got); end
    n_cmp++; if (x_addr !== 8'd255)      begin n_err++; $display("FAIL wrap_x_addr got=%0d want=255", x_addr); end
  endtask

  task automatic test_random();
    int lat; logic [ACC_W-1:0] got; bit yv2; bit to; exp_t e;
    logic [7:0] nv;
    for (int r = 0; r < 3; r++) begin
      setup_random();
      nv = 8'($urandom_range(0, 255));
      run_sample(nv, lat, got, yv2, to);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e.y) begin n_err++; $display("FAIL random_y run=%0d got=%h want=%h", r, got, e.y); end
      n_cmp++; if (lat != 145)  begin n_err++; $display("FAIL random_latency run=%0d got=%0d want=145", r, lat); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [ACC_W-1:0] got; bit yv2; bit to; exp_t e;
    setup_random();
    n_in  = 8'd77;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // With r_j=2 each band is 9 cycles; band 7's first ACC is cycle 58.
    repeat (58) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (y !== '0)           begin n_err++; $display("FAIL midrst_y got=%h want=0", y); end
    n_cmp++; if (y_valid !== 1'b0)   begin n_err++; $display("FAIL midrst_y_valid got=%b want=0", y_valid); end
    n_cmp++; if (rj_addr !== 4'd0)   begin n_err++; $display("FAIL midrst_rj_addr got=%h want=0", rj_addr); end
    n_cmp++; if (coef_addr !== 9'd0) begin n_err++; $display("FAIL midrst_coef_addr got=%h want=0", coef_addr); end
    n_cmp++; if (x_addr !== 8'd0)    begin n_err++; $display("FAIL midrst_x_addr got=%h want=0", x_addr); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sample(8'd77, lat, got, yv2, to);
    e = exp_q.pop_front();
    n_cmp++; if (got !== e.y)  begin n_err++; $display("FAIL midrst_fresh_y got=%h want=%h", got, e.y); end
    n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL midrst_fresh_latency got=%0d want=%0d", lat, e.lat); end
  endtask

  task automatic test_ignore_start();
    exp_t e; int cyc; int vcount; int first_lat; logic [ACC_W-1:0] got;
    setup_random();
    e.y   = golden_y(8'd200);
    e.lat = golden_lat();
    exp_q.push_back(e);
    vcount    = 0;
    first_lat = -1;
    got       = '0;
    n_in  = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      if (y_valid) begin
        vcount++;
        if (first_lat < 0) begin
          first_lat = cyc;
          got       = y;
        end
      end
      // Pulse once mid-run (different n) and once into the DONE cycle.
      if (cyc == 9)         begin start = 1'b1; n_in = 8'd3; end
      if (cyc == 10)        start = 1'b0;
      if (cyc == e.lat - 1) start = 1'b1;
      if (cyc == e.lat)     start = 1'b0;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    $display("run n=200 with extra starts: strobes=%0d latency=%0d y=%h", vcount, first_lat, got);
    n_cmp++; if (vcount != 1)       begin n_err++; $display("FAIL ignore_strobe_count got=%0d want=1", vcount); end
    n_cmp++; if (got !== e.y)       begin n_err++; $display("FAIL ignore_y got=%h want=%h", got, e.y); end
    n_cmp++; if (first_lat != e.lat) begin n_err++; $display("FAIL ignore_latency got=%0d want=%0d", first_lat, e.lat); end
    n_cmp++; if (y !== e.y)         begin n_err++; $display("FAIL ignore_y_held got=%h want=%h", y, e.y); end
  endtask

  initial begin
    test_reset();
    test_zero_bands();
    test_single_tap();
    test_wrap();
    test_random();
    test_reset_mid();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uj_sequencer.md
Name: uj_sequencer

Overview:
Per-sample controller for the MSDAP u_j datapath.
- On a start pulse it walks j = 1..16 and reads each band's coefficient count r_j.
- For each coefficient it fetches the coefficient, then fetches x(n-k).
- It accumulates signed u_j and folds each u_j into y(n) by Horner shift-add.
- Sits between the sample-buffer writer and the output serializer; owns the read ports of the r_j, coefficient and data memories.

Parameters:
DATA_W, 16, input sample width
ACC_W, 40, u_j / y accumulator width
FRAC_W, 16, zero bits appended below a sample when aligned into ACC_W
NBANDS, 16, number of u_j terms

Ports:
Sclk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: compute y for sample pointer n
n  in  8  data-buffer address of newest sample x(n)
busy  out  1  high from accepted start until y_valid cycle, inclusive
rj_addr  out  4  r_j memory address, j-1
rj_data  in  8  coefficient count for band j, valid one cycle after rj_addr
coef_addr  out  9  coefficient memory address
coef_data  in  9  [8] sign (1 = subtract), [7:0] delay k; valid one cycle after coef_addr
x_addr  out  8  data buffer address
x_data  in  DATA_W  sample, valid one cycle after x_addr
y  out  ACC_W  result, held until next y_valid
y_valid  out  1  one-cycle strobe, y updated

Behaviour:
- Reset (Reset_n low at a Sclk edge), including mid-computation:
  - state = IDLE; busy, y_valid = 0; y, u_j, y_acc = 0.
  - rj_addr, coef_addr, x_addr = 0; coefficient pointer = 0; j = 0.
- Memory reads are synchronous, latency 1. Addresses are registered outputs.
- FSM states:
  - IDLE: start=1 latches n, clears y_acc, j=0, coef pointer=0 -> RJ_RD. start while not IDLE is ignored.
  - RJ_RD (1 cycle): rj_addr=j -> RJ_CAP.
  - RJ_CAP (1 cycle): cnt=rj_data, u_j=0. cnt==0 -> SHIFT, else -> CF_RD.
  - CF_RD: coef_addr=pointer; pointer += 1 (9-bit, wraps 511->0) -> X_RD.
  - X_RD: x_addr = n - coef_data[7:0] (mod 256, wraps); latch sign -> ACC.
  - ACC: operand = {sign-extend(x_data) to ACC_W-FRAC_W bits, FRAC_W zeros}. u_j = u_j ± operand, mod 2^ACC_W, no saturation. cnt -= 1; cnt==0 -> SHIFT, else -> CF_RD.
  - SHIFT: y_acc = (y_acc + u_j) >>> 1, arithmetic, ACC_W wide. j==15 -> DONE, else j+=1 -> RJ_RD.
  - DONE: y=y_acc, y_valid=1 for this cycle only -> IDLE.
- Latency: y_valid is high exactly 3*NBANDS + 3*sum(r_j) + 1 cycles after the start edge. With all r_j=0 this is 49 cycles.
- busy deasserts in the cycle after DONE.
- A start coincident with the DONE cycle is ignored.
- r_j=0 bands still take the SHIFT, so weights are unchanged.
- Coefficient pointer is not reset between bands; bands are packed contiguously from address 0.

Optional Feature:
UJ_TAP_EN
- Defined: adds ports uj_out (ACC_W), uj_idx (4) and uj_valid (1).
  - In each SHIFT cycle, uj_valid=1, uj_out=u_j, uj_idx=j.
  - All three reset to 0.
- Undefined: ports absent; no timing change.

Decomposition:
- Package msdap_pkg holds:
  - DATA_W, ACC_W, FRAC_W, NBANDS;
  - state enum (IDLE, RJ_RD, RJ_CAP, CF_RD, X_RD, ACC, SHIFT, DONE);
  - coefficient field positions: sign bit 8, delay [7:0].
- Natural sub-module: uj_accumulator, the ACC-state alignment, add/sub and u_j register. The FSM and addressing stay in uj_sequencer.

Test Plan:
- All r_j=0, start with n=5 -> y_valid at cycle 49, y=0, busy high cycles 1..49.
- r_1=1, coef[0]=+k0, x[5]=0x0001, n=5 -> y = 0x10000 >>> 16 = 0x0000000001.
- r_16=1 only, coef[0]=sign|k2, n=1, x[255]=0x7FFF -> x_addr=255 (wrap); y = -(0x7FFF<<16)>>>1 = 0xFFC0008000.
- Each r_j=2, random coefficients and data -> y matches golden Horner model; y_valid at 3*16+3*32+1 = 145 cycles.
- Reset_n low during ACC of band 7 -> next cycle busy=0, y=0, addresses=0. A fresh start gives the correct result.
- start pulsed while busy and in the DONE cycle -> ignored: exactly one y_valid, y unchanged from the single-run value.
